// File: rtl/ram_1r1w_bist_if.sv
// RAM-side bus of the BIST: the BIST drives the write port and read address, and the RAM returns read data.
interface ram_1r1w_bist_if #(
    parameter int width_p = 8,
    parameter int depth_p = 16
) ();
    localparam int addr_w_lp = $clog2(depth_p);

    logic                 wr_valid_o;
    logic [addr_w_lp-1:0] wr_addr_o;
    logic [width_p-1:0]   wr_data_o;
    logic [addr_w_lp-1:0] rd_addr_o;
    logic [width_p-1:0]   rd_data_i;

    modport master (
        output wr_valid_o, wr_addr_o, wr_data_o, rd_addr_o,
        input  rd_data_i
    );

    modport slave (
        input  wr_valid_o, wr_addr_o, wr_data_o, rd_addr_o,
        output rd_data_i
    );
endinterface

// File: rtl/ram_1r1w_bist.sv
// Built-in self-test for one ram_1r1w_sync: writes an alternating seed/~seed pattern, reads it back, counts mismatches.
// Define RAM_1R1W_BIST_FAIL_CAPTURE_EN to add first-mismatch capture ports (fail_valid_o/fail_addr_o/fail_data_o).
module ram_1r1w_bist #(
    parameter int          width_p = 8,
    parameter int          depth_p = 16,
    parameter int unsigned seed_p  = 32'hA5
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       pass_o,
    output logic [31:0]                error_count_o,
`ifdef RAM_1R1W_BIST_FAIL_CAPTURE_EN
    output logic                       fail_valid_o,
    output logic [$clog2(depth_p)-1:0] fail_addr_o,
    output logic [width_p-1:0]         fail_data_o,
`endif
    ram_1r1w_bist_if.master            ram_if
);
    localparam int                   addr_w_lp    = $clog2(depth_p);
    localparam logic [width_p-1:0]   seed_lp      = width_p'(seed_p);
    localparam logic [addr_w_lp-1:0] last_addr_lp = addr_w_lp'(depth_p - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t               r_state;
    logic [addr_w_lp-1:0] r_addr;
    logic [width_p-1:0]   r_exp_data;
    logic                 r_exp_valid;
    logic [31:0]          r_error_count;

    state_t               w_state_next;
    logic [addr_w_lp-1:0] w_addr_next;
    logic                 w_start_run;
    logic                 w_last;
    logic                 w_mismatch;

    function automatic logic [width_p-1:0] pattern(input logic [addr_w_lp-1:0] a);
        return a[0] ? ~seed_lp : seed_lp;
    endfunction

    assign w_last = (r_addr == last_addr_lp);

    // NOTE: !== makes an X/Z read count as a mismatch in simulation; synthesis treats it as a plain !=.
    assign w_mismatch = r_exp_valid && (ram_if.rd_data_i !== r_exp_data);

    // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
    always_comb begin
        w_state_next      = r_state;
        w_addr_next       = r_addr;
        w_start_run       = 1'b0;
        busy_o            = 1'b0;
        done_o            = 1'b0;
        pass_o            = 1'b0;
        ram_if.wr_valid_o = 1'b0;
        ram_if.wr_addr_o  = r_addr;
        ram_if.wr_data_o  = pattern(r_addr);
        ram_if.rd_addr_o  = '0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                done_o = (r_state == ST_DONE);
                pass_o = (r_state == ST_DONE) && (r_error_count == '0);
                if (start_i) begin
                    w_state_next = ST_WRITE;
                    w_addr_next  = '0;
                    w_start_run  = 1'b1;
                end
            end
            ST_WRITE: begin
                busy_o            = 1'b1;
                ram_if.wr_valid_o = 1'b1;
                w_addr_next       = r_addr + addr_w_lp'(1);
                if (w_last) begin
                    w_state_next = ST_READ;
                    w_addr_next  = '0;
                end
            end
            ST_READ: begin
                busy_o           = 1'b1;
                ram_if.rd_addr_o = r_addr;
                w_addr_next      = r_addr + addr_w_lp'(1);
                if (w_last) begin
                    w_state_next = ST_DRAIN;
                    w_addr_next  = '0;
                end
            end
            ST_DRAIN: begin
                busy_o       = 1'b1;
                w_state_next = ST_DONE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values, whatever the block order.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_exp_data    <= seed_lp;
            r_exp_valid   <= 1'b0;
            r_error_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_addr      <= w_addr_next;
            // Expected data lines up with the RAM's one-cycle read latency.
            r_exp_data  <= pattern(r_addr);
            r_exp_valid <= (r_state == ST_READ);
            if (w_start_run) begin
                r_error_count <= '0;
            end else if (w_mismatch && (r_error_count != '1)) begin
                r_error_count <= r_error_count + 32'd1;
            end
        end
    end

    assign error_count_o = r_error_count;

`ifdef RAM_1R1W_BIST_FAIL_CAPTURE_EN
    logic [addr_w_lp-1:0] r_exp_addr;
    logic                 r_fail_valid;
    logic [addr_w_lp-1:0] r_fail_addr;
    logic [width_p-1:0]   r_fail_data;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_exp_addr   <= '0;
            r_fail_valid <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_data  <= '0;
        end else begin
            r_exp_addr <= r_addr;
            if (w_start_run) begin
                r_fail_valid <= 1'b0;
                r_fail_addr  <= '0;
                r_fail_data  <= '0;
            end else if (w_mismatch && !r_fail_valid) begin
                r_fail_valid <= 1'b1;
                r_fail_addr  <= r_exp_addr;
                r_fail_data  <= ram_if.rd_data_i;
            end
        end
    end

    assign fail_valid_o = r_fail_valid;
    assign fail_addr_o  = r_fail_addr;
    assign fail_data_o  = r_fail_data;
`endif
endmodule
